float32_sum_stream: RTL and testbench
=====================================

Name: float32_sum_stream

Overview:
Streaming float32 reduction unit with valid/ready handshake and latency-matched valid/last tracking. Each accepted vector of VALUES float32 lanes is summed by a zero-padded binary tree of FLOAT32_ADD_PIPELINE instances. Mode 0 emits one sum per vector. Mode 1 accumulates vector sums across a frame, terminated by in_last, and emits one total per frame. It sits between lane-parallel datapaths (dot products, window sums) and scalar consumers.

Parameters:
BITWIDTH, 32, lane width; float32 only, so fixed at 32
VALUES, 3, number of input lanes (1..VALUES_POWER)
VALUES_POWER, 4, tree leaf count; power of two, >= VALUES
LOG2_POWER, 2, log2(VALUES_POWER) = tree depth
ADD_LATENCY, 2, clock latency of one FLOAT32_ADD_PIPELINE
FIFO_DEPTH, 4, mode-1 buffer entries for tree results; power of two, >= 2

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
mode  in  1  0 = per-vector sum, 1 = frame accumulate; change only while busy=0
in_valid  in  1  input vector valid
in_last  in  1  last vector of frame; ignored in mode 0
data  in  BITWIDTH*VALUES  lane i = data[i*32+31 : i*32]
in_ready  out  1  vector accepted when in_valid && in_ready
out_valid  out  1  one-cycle pulse per result; no output backpressure
out_last  out  1  mode 0: copy of the vector's in_last; mode 1: always 1
result  out  BITWIDTH  float32 sum
busy  out  1  any vector in tree, FIFO or accumulator

Behaviour:
- Reset: out_valid=0, out_last=0, result=0, busy=0, in_ready=1, FIFO empty, accumulator empty, FSM=IDLE.
- Tree:
  - Leaves VALUES..VALUES_POWER-1 are tied to 32'h0000_0000.
  - TREE_LAT = LOG2_POWER*ADD_LATENCY.
  - A shift register of {valid,last} with depth TREE_LAT runs alongside the tree and is cleared by rst.
  - Adder internals are not reset; stale tree data is never qualified.
- Mode 0:
  - in_ready=1 always.
  - Vector accepted at cycle t gives out_valid=1 at cycle t+TREE_LAT+1, from the registered output.
  - Full throughput: 1 vector per cycle.
- Mode 1:
  - Tree outputs {sum,last} are pushed into the FIFO.
  - in_ready = (fifo_count + tree_inflight) < FIFO_DEPTH. This credit check guarantees no overflow. Pushing to a full FIFO is impossible by design; assert in sim.
- Accumulator FSM (mode 1), states IDLE, WAIT:
  - IDLE, FIFO non-empty, accumulator empty: acc <= head; pop. If head.last: emit acc, stay empty. This is a load, not 0+x, so a single-vector frame passes its value bit-exact.
  - IDLE, FIFO non-empty, accumulator holds a value: drive adder with (acc, head); pop; latch head.last; counter <= ADD_LATENCY; go to WAIT.
  - WAIT: decrement the counter. At 0: acc <= adder out; if the latched last is set, emit and mark acc empty; return to IDLE.
  - Accumulation rate is one element per ADD_LATENCY+1 cycles; sustained mode-1 input is throttled via in_ready.
- Emit: result registered, out_valid=1 for exactly one cycle, out_last=1.
- Simultaneous FIFO push and pop in one cycle: allowed, count unchanged.
- A frame of 1 vector: no adder op. A new frame may start immediately after in_last; its elements queue in the FIFO.
- rst mid-frame:
  - Partial accumulation is discarded; no out_valid is produced for it.
  - FIFO and valid pipeline are flushed.
  - The first vector after rst starts a new frame.
- busy=0 only when the valid pipeline is empty, the FIFO is empty, FSM=IDLE and the accumulator is empty.
- No NaN/Inf handling beyond what the adder does; the block adds no rounding of its own.

Test Plan:
- Mode 0, defaults, one vector {1.0,2.0,3.0} (3F800000,40000000,40400000) at cycle t -> out_valid at t+5 with result=40C00000 (6.0); out_last mirrors in_last.
- Mode 0, 10 back-to-back vectors of {1,2,3} -> 10 consecutive out_valid pulses of 40C00000; in_ready never drops.
- Mode 1, frame of 3 vectors {1,2,3}, last on the 3rd -> exactly one pulse, result=41900000 (18.0), out_last=1.
- Mode 1, single-vector frame {1,2,3} with in_last -> result=40C00000 with no adder op issued.
- Mode 1 backpressure: 8 vectors {1,2,3} with in_valid held high, last on the 8th -> in_ready drops at least once, no FIFO overflow assertion fires, result=42400000 (48.0).
- Mode 1, rst asserted after 2 vectors of a frame, then frame {0.5,0.5,0.5} (3F000000 x3) with last -> only one output, 3FC00000 (1.5); busy returns to 0 afterwards.

Source files
------------

// File: rtl/float32_sum_stream_if.sv
// Handshake bundle for float32_sum_stream: the vector input side, the scalar
// result side and the status flags travel together between producer and reducer.
interface float32_sum_stream_if #(
   parameter int BITWIDTH = 32,
   parameter int VALUES   = 3
);
   logic                       mode;
   logic                       in_valid;
   logic                       in_last;
   logic [BITWIDTH*VALUES-1:0] data;
   logic                       in_ready;
   logic                       out_valid;
   logic                       out_last;
   logic [BITWIDTH-1:0]        result;
   logic                       busy;

   modport master (
      output mode, in_valid, in_last, data,
      input  in_ready, out_valid, out_last, result, busy
   );

   modport slave (
      input  mode, in_valid, in_last, data,
      output in_ready, out_valid, out_last, result, busy
   );
endinterface

// File: rtl/float32_sum_stream.sv
// Streaming float32 reducer. Each accepted vector is summed by a balanced
// binary tree of pipelined float adders (unused leaves are +0). Mode 0 emits
// one sum per vector; mode 1 queues tree sums in a credit-protected FIFO and
// folds them into an accumulator, emitting one total per in_last-terminated frame.
module float32_sum_stream #(
   parameter int BITWIDTH     = 32,
   parameter int VALUES       = 3,
   parameter int VALUES_POWER = 4,
   parameter int LOG2_POWER   = 2,
   parameter int ADD_LATENCY  = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input logic                 clk,
   input logic                 rst,
   float32_sum_stream_if.slave bus
);

   localparam int TREE_LAT = LOG2_POWER * ADD_LATENCY;
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int CTR_W    = $clog2(ADD_LATENCY + 1);

   // Intermediate adder state between the align/add stage and the round stage.
   typedef struct packed {
      logic               special;
      logic [31:0]        special_val;
      logic               sign;
      logic               zero_sign;
      logic signed [9:0]  exp;
      logic [27:0]        mag;
   } add_mid_t;

   typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

   // Leading-zero count of the 27-bit pre-normalisation magnitude.
   function automatic int f_lzc27(input logic [26:0] v);
      int   c;
      logic seen;
      c    = 0;
      seen = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (v[i]) seen = 1'b1;
         else if (!seen) c = c + 1;
      end
      return c;
   endfunction

   // Exponent saturation: overflow becomes infinity, underflow flushes to zero.
   function automatic logic [31:0] f_sat_pack(input logic sign, input logic signed [9:0] e,
                                              input logic [22:0] frac);
      if (e >= 10'sd255)    return {sign, 8'hFF, 23'd0};
      else if (e <= 10'sd0) return {sign, 31'd0};
      else                  return {sign, e[7:0], frac};
   endfunction

   // Swap operands by magnitude, align the smaller one with guard/round/sticky
   // bits, then add or subtract magnitudes. Denormal inputs are treated as zero.
   function automatic add_mid_t f_add_align(input logic [31:0] a, input logic [31:0] b);
      add_mid_t    m;
      logic [31:0] hi, lo;
      logic [23:0] mx, my;
      logic [7:0]  d;
      logic [49:0] ext;
      logic [26:0] ax, ay;
      logic        a_nan, b_nan, a_inf, b_inf;
      m   = '0;
      ext = '0;
      if (a[30:0] >= b[30:0]) begin hi = a; lo = b; end
      else begin hi = b; lo = a; end
      mx = (hi[30:23] != 8'd0) ? {1'b1, hi[22:0]} : 24'd0;
      my = (lo[30:23] != 8'd0) ? {1'b1, lo[22:0]} : 24'd0;
      d  = hi[30:23] - lo[30:23];
      ax = {mx, 3'b000};
      if (d > 8'd26) begin
         ay = {26'd0, |my};
      end else begin
         ext = {my, 26'd0} >> d;
         ay  = {ext[49:24], |ext[23:0]};
      end
      m.sign      = hi[31];
      m.zero_sign = a[31] & b[31];
      m.exp       = $signed({2'b00, hi[30:23]});
      if (hi[31] == lo[31]) m.mag = {1'b0, ax} + {1'b0, ay};
      else                  m.mag = {1'b0, ax} - {1'b0, ay};
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      m.special = a_nan | b_nan | a_inf | b_inf;
      if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) m.special_val = 32'h7FC0_0000;
      else if (a_inf)                                              m.special_val = a;
      else                                                         m.special_val = b;
      return m;
   endfunction

   // Normalise, round to nearest-even and pack.
   function automatic logic [31:0] f_add_round(input add_mid_t m);
      logic [26:0]       n;
      logic signed [9:0] e;
      logic [24:0]       mr;
      logic              inc;
      int                lz;
      if (m.special)        return m.special_val;
      if (m.mag == 28'd0)   return {m.zero_sign, 31'd0};
      if (m.mag[27]) begin
         n = {m.mag[27:2], m.mag[1] | m.mag[0]};
         e = m.exp + 10'sd1;
      end else begin
         lz = f_lzc27(m.mag[26:0]);
         n  = m.mag[26:0] << lz;
         e  = m.exp - $signed(10'(lz));
      end
      inc = n[2] & (n[1] | n[0] | n[3]);
      mr  = {1'b0, n[26:3]} + {24'd0, inc};
      if (mr[24]) begin
         e  = e + 10'sd1;
         mr = mr >> 1;
      end
      return f_sat_pack(m.sign, e, mr[22:0]);
   endfunction

   function automatic int f_popcount(input logic [TREE_LAT-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < TREE_LAT; i++) if (v[i]) c = c + 1;
      return c;
   endfunction

   // Adder slot 0 is the accumulator adder; slots 1..VALUES_POWER-1 are tree
   // nodes in heap order (node n has children 2n and 2n+1, leaves at VALUES_POWER+k).
   logic [31:0]            w_add_a [0:VALUES_POWER-1];
   logic [31:0]            w_add_b [0:VALUES_POWER-1];
   logic [31:0]            w_add_y [0:VALUES_POWER-1];
   logic [31:0]            w_node  [1:2*VALUES_POWER-1];

   logic [TREE_LAT-1:0]    r_vld_pipe;
   logic [TREE_LAT-1:0]    r_last_pipe;
   logic [31:0]            r_fifo_data [0:FIFO_DEPTH-1];
   logic                   r_fifo_last [0:FIFO_DEPTH-1];
   logic [PTR_W-1:0]       r_wptr, r_rptr;
   logic [CNT_W-1:0]       r_count;
   state_t                 r_state;
   logic                   r_acc_full;
   logic [31:0]            r_acc;
   logic [31:0]            r_op_b;
   logic                   r_op_last;
   logic [CTR_W-1:0]       r_ctr;
   logic                   r_out_valid, r_out_last;
   logic [31:0]            r_result;

   logic                   w_in_ready, w_accept;
   logic                   w_tree_vld, w_tree_last;
   logic                   w_push, w_pop;
   logic [31:0]            w_head_data;
   logic                   w_head_last;

   for (genvar k = 0; k < VALUES_POWER; k++) begin : g_leaf
      if (k < VALUES) begin : g_lane
         assign w_node[VALUES_POWER+k] = bus.data[k*BITWIDTH +: BITWIDTH];
      end else begin : g_pad
         assign w_node[VALUES_POWER+k] = 32'h0000_0000;
      end
   end

   for (genvar n = 1; n < VALUES_POWER; n++) begin : g_tree
      assign w_add_a[n] = w_node[2*n];
      assign w_add_b[n] = w_node[2*n+1];
      assign w_node[n]  = w_add_y[n];
   end

   // The accumulator adder sees the FIFO head in the pop cycle and the held
   // copy afterwards, so its inputs stay constant for the whole WAIT interval.
   assign w_add_a[0] = r_acc;
   assign w_add_b[0] = (r_state == S_IDLE) ? w_head_data : r_op_b;

   for (genvar n = 0; n < VALUES_POWER; n++) begin : g_add
      add_mid_t    r_mid_p0;
      logic [31:0] r_sum_p [1:ADD_LATENCY-1];
      // Adder datapath; not reset, results are only used when qualified by valid.
      always_ff @(posedge clk) begin
         // p0: align and add
         r_mid_p0    <= f_add_align(w_add_a[n], w_add_b[n]);
         // p1: normalise and round; later stages only delay
         r_sum_p[1]  <= f_add_round(r_mid_p0);
         for (int s = 2; s < ADD_LATENCY; s++) r_sum_p[s] <= r_sum_p[s-1];
      end
      assign w_add_y[n] = r_sum_p[ADD_LATENCY-1];
   end

   // Credit check: everything already in the FIFO plus everything still in the
   // tree must fit, so a tree result always finds a free FIFO slot.
   assign w_in_ready  = !bus.mode || ((int'(r_count) + f_popcount(r_vld_pipe)) < FIFO_DEPTH);
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_tree_vld  = r_vld_pipe[TREE_LAT-1];
   assign w_tree_last = r_last_pipe[TREE_LAT-1];
   assign w_push      = w_tree_vld && bus.mode;
   assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
   assign w_head_data = r_fifo_data[r_rptr];
   assign w_head_last = r_fifo_last[r_rptr];

   // Valid/last shift register matching the tree latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
      end else begin
         r_vld_pipe  <= {r_vld_pipe[TREE_LAT-2:0], w_accept};
         r_last_pipe <= {r_last_pipe[TREE_LAT-2:0], bus.in_last};
      end
   end

   // Tree-result FIFO; push and pop in the same cycle leave the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_fifo_data[r_wptr] <= w_node[1];
            r_fifo_last[r_wptr] <= w_tree_last;
            r_wptr              <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Accumulator FSM and registered output for both modes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc_full  <= 1'b0;
         r_ctr       <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_result    <= '0;
      end else begin
         r_out_valid <= 1'b0;
         if (!bus.mode && w_tree_vld) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_tree_last;
            r_result    <= w_node[1];
         end
         case (r_state)
            S_IDLE: begin
               if (r_count != '0) begin
                  if (!r_acc_full) begin
                     // First element of a frame is loaded, never added to zero.
                     r_acc <= w_head_data;
                     if (w_head_last) begin
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b1;
                        r_result    <= w_head_data;
                        r_acc_full  <= 1'b0;
                     end else begin
                        r_acc_full  <= 1'b1;
                     end
                  end else begin
                     r_op_b    <= w_head_data;
                     r_op_last <= w_head_last;
                     r_ctr     <= CTR_W'(ADD_LATENCY);
                     r_state   <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               r_ctr <= r_ctr - 1'b1;
               if (r_ctr == CTR_W'(1)) begin
                  r_acc   <= w_add_y[0];
                  r_state <= S_IDLE;
                  if (r_op_last) begin
                     r_out_valid <= 1'b1;
                     r_out_last  <= 1'b1;
                     r_result    <= w_add_y[0];
                     r_acc_full  <= 1'b0;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_last  = r_out_last;
   assign bus.result    = r_result;
   assign bus.busy      = (|r_vld_pipe) || (r_count != '0) || (r_state != S_IDLE) || r_acc_full;

   a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_push && (r_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_float32_sum_stream.sv
// Directed bench for float32_sum_stream: reset state, mode-0 latency and
// throughput, mode-1 frame accumulation, single-vector frames, backpressure
// and reset in the middle of a frame.
module tb_float32_sum_stream;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   float32_sum_stream_if #(.BITWIDTH(32), .VALUES(3)) bus ();

   float32_sum_stream #(
      .BITWIDTH(32), .VALUES(3), .VALUES_POWER(4), .LOG2_POWER(2),
      .ADD_LATENCY(2), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   localparam logic [95:0] V123  = {32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
   localparam logic [95:0] VHALF = {32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000};

   int          n_vec = 0;
   int          n_bad = 0;
   int          n_out = 0;
   logic [31:0] mon_result = '0;
   logic        mon_last = 1'b0;

   // Output pulse monitor, sampled shortly after each rising edge.
   always @(posedge clk) begin
      #2;
      if (bus.out_valid === 1'b1) begin
         n_out      = n_out + 1;
         mon_result = bus.result;
         mon_last   = bus.out_last;
      end
   end

   // Called at a negedge; holds the vector until accepted, returns at a negedge.
   task automatic send_vec(input logic [95:0] d, input logic last, output int stalls);
      int guard;
      stalls       = 0;
      guard        = 0;
      bus.in_valid = 1'b1;
      bus.data     = d;
      bus.in_last  = last;
      while (bus.in_ready !== 1'b1 && guard < 200) begin
         @(negedge clk);
         stalls = stalls + 1;
         guard  = guard + 1;
      end
      if (guard >= 200) begin
         n_vec = n_vec + 1;
         n_bad = n_bad + 1;
         $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_result(input int base, input string tag);
      int guard;
      guard = 0;
      while (n_out <= base && guard < 300) begin
         @(negedge clk);
         guard = guard + 1;
      end
      n_vec = n_vec + 1;
      if (n_out <= base) begin
         n_bad = n_bad + 1;
         $display("FAIL %s_timeout: got %0d pulses, required at least 1", tag, n_out - base);
      end
   endtask

   task automatic wait_idle(input string tag);
      int guard;
      guard = 0;
      while (bus.busy !== 1'b0 && guard < 300) begin
         @(negedge clk);
         guard = guard + 1;
      end
      n_vec = n_vec + 1;
      if (bus.busy !== 1'b0) begin
         n_bad = n_bad + 1;
         $display("FAIL %s_idle: busy=%b, required 0", tag, bus.busy);
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.mode     = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.data     = '0;
      repeat (3) @(negedge clk);
      n_vec = n_vec + 5;
      if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
      if (bus.out_last  !== 1'b0) begin n_bad++; $display("FAIL rst_out_last: got %b required 0", bus.out_last); end
      if (bus.result !== 32'h0)   begin n_bad++; $display("FAIL rst_result: got %h required 00000000", bus.result); end
      if (bus.busy      !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
      if (bus.in_ready  !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b required 1", bus.in_ready); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mode0_latency();
      logic exp_v;
      bus.in_valid = 1'b1;
      bus.data     = V123;
      bus.in_last  = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) begin bus.in_valid = 1'b0; bus.in_last = 1'b0; end
         exp_v = (k == 5);
         n_vec = n_vec + 1;
         if (bus.out_valid !== exp_v) begin
            n_bad++;
            $display("FAIL m0_lat_valid cycle %0d: got %b required %b", k, bus.out_valid, exp_v);
         end
         if (k == 5) begin
            n_vec = n_vec + 2;
            if (bus.result !== 32'h40C0_0000) begin n_bad++; $display("FAIL m0_lat_result: got %h required 40c00000", bus.result); end
            if (bus.out_last !== 1'b1) begin n_bad++; $display("FAIL m0_lat_last: got %b required 1", bus.out_last); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic exp_v, exp_l;
      for (int k = 0; k <= 15; k++) begin
         exp_v = (k >= 5) && (k <= 14);
         exp_l = ((k - 5) % 3) == 0;
         n_vec = n_vec + 1;
         if (bus.out_valid !== exp_v) begin
            n_bad++;
            $display("FAIL b2b_valid cycle %0d: got %b required %b", k, bus.out_valid, exp_v);
         end
         if (exp_v) begin
            n_vec = n_vec + 2;
            if (bus.result !== 32'h40C0_0000) begin n_bad++; $display("FAIL b2b_result cycle %0d: got %h required 40c00000", k, bus.result); end
            if (bus.out_last !== exp_l) begin n_bad++; $display("FAIL b2b_last cycle %0d: got %b required %b", k, bus.out_last, exp_l); end
         end
         if (k < 10) begin
            n_vec = n_vec + 1;
            if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready cycle %0d: got %b required 1", k, bus.in_ready); end
            bus.in_valid = 1'b1;
            bus.data     = V123;
            bus.in_last  = ((k % 3) == 0);
         end else begin
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_mode1_frame();
      int base, st;
      wait_idle("m1_pre");
      bus.mode = 1'b1;
      @(negedge clk);
      base = n_out;
      send_vec(V123, 1'b0, st);
      send_vec(V123, 1'b0, st);
      send_vec(V123, 1'b1, st);
      wait_result(base, "m1_frame");
      n_vec = n_vec + 2;
      if (mon_result !== 32'h4190_0000) begin n_bad++; $display("FAIL m1_frame_result: got %h required 41900000", mon_result); end
      if (mon_last !== 1'b1) begin n_bad++; $display("FAIL m1_frame_last: got %b required 1", mon_last); end
      repeat (20) @(negedge clk);
      n_vec = n_vec + 1;
      if (n_out - base != 1) begin n_bad++; $display("FAIL m1_frame_count: got %0d pulses required 1", n_out - base); end
      wait_idle("m1_frame");
   endtask

   task automatic test_single_frame();
      logic exp_v;
      n_vec = n_vec + 1;
      if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL single_in_ready: got %b required 1", bus.in_ready); end
      bus.in_valid = 1'b1;
      bus.data     = V123;
      bus.in_last  = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) begin bus.in_valid = 1'b0; bus.in_last = 1'b0; end
         exp_v = (k == 6);
         n_vec = n_vec + 1;
         if (bus.out_valid !== exp_v) begin
            n_bad++;
            $display("FAIL single_valid cycle %0d: got %b required %b", k, bus.out_valid, exp_v);
         end
         if (k == 6) begin
            n_vec = n_vec + 2;
            if (bus.result !== 32'h40C0_0000) begin n_bad++; $display("FAIL single_result: got %h required 40c00000", bus.result); end
            if (bus.out_last !== 1'b1) begin n_bad++; $display("FAIL single_last: got %b required 1", bus.out_last); end
         end
      end
      wait_idle("single");
   endtask

   task automatic test_backpressure();
      int base, st, stalls;
      base   = n_out;
      stalls = 0;
      for (int i = 0; i < 8; i++) begin
         send_vec(V123, (i == 7), st);
         stalls = stalls + st;
      end
      n_vec = n_vec + 1;
      if (stalls == 0) begin n_bad++; $display("FAIL bp_stall: got %0d stall cycles required >0", stalls); end
      wait_result(base, "bp");
      n_vec = n_vec + 2;
      if (mon_result !== 32'h4240_0000) begin n_bad++; $display("FAIL bp_result: got %h required 42400000", mon_result); end
      if (mon_last !== 1'b1) begin n_bad++; $display("FAIL bp_last: got %b required 1", mon_last); end
      repeat (20) @(negedge clk);
      n_vec = n_vec + 1;
      if (n_out - base != 1) begin n_bad++; $display("FAIL bp_count: got %0d pulses required 1", n_out - base); end
      wait_idle("bp");
   endtask

   task automatic test_reset_midframe();
      int base, st;
      base = n_out;
      send_vec(V123, 1'b0, st);
      send_vec(V123, 1'b0, st);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_vec = n_vec + 2;
      if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b required 0", bus.busy); end
      if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b required 0", bus.out_valid); end
      rst = 1'b0;
      repeat (10) @(negedge clk);
      n_vec = n_vec + 1;
      if (n_out != base) begin n_bad++; $display("FAIL midrst_no_output: got %0d pulses required 0", n_out - base); end
      send_vec(VHALF, 1'b1, st);
      wait_result(base, "midrst");
      n_vec = n_vec + 2;
      if (mon_result !== 32'h3FC0_0000) begin n_bad++; $display("FAIL midrst_result: got %h required 3fc00000", mon_result); end
      if (mon_last !== 1'b1) begin n_bad++; $display("FAIL midrst_last: got %b required 1", mon_last); end
      repeat (20) @(negedge clk);
      n_vec = n_vec + 1;
      if (n_out - base != 1) begin n_bad++; $display("FAIL midrst_count: got %0d pulses required 1", n_out - base); end
      wait_idle("midrst");
   endtask

   initial begin
      rst          = 1'b1;
      bus.mode     = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.data     = '0;
      test_reset();
      test_mode0_latency();
      test_back_to_back();
      test_mode1_frame();
      test_single_frame();
      test_backpressure();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
